// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl: flush/stall arbiter for an in-order pipeline.
//   Stall resolution, oldest-wins flush arbitration and the flush/stall/bubble
//   controls are same-cycle combinational. The redirect is registered, and
//   IF flush is held for HOLD_CYCLES cycles to cover fetches already in flight.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   flush_req       per-stage flush request (stage s flushes stages 0..s-1); bit 0 ignored
//   flush_tgt       per-stage redirect target, stage s at [s*ADDR_W +: ADDR_W]
//   stall_req       per-stage "cannot advance" request
//   flush           clear pipeline register of stage i (combinational)
//   stall           hold pipeline register of stage i (combinational)
//   bubble          insert NOP into stage i (combinational)
//   redirect_valid  one-cycle pulse after an accepted flush
//   redirect_pc     registered winning target
//   busy            flush hold in progress (registered)
module pipe_flush_ctrl #(
    parameter int unsigned NUM_STAGES  = 5,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_STAGES-1:0]        flush_req,
    input  logic [NUM_STAGES*ADDR_W-1:0] flush_tgt,
    input  logic [NUM_STAGES-1:0]        stall_req,
    output logic [NUM_STAGES-1:0]        flush,
    output logic [NUM_STAGES-1:0]        stall,
    output logic [NUM_STAGES-1:0]        bubble,
    output logic                         redirect_valid,
    output logic [ADDR_W-1:0]            redirect_pc,
    output logic                         busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 3;

    logic [CNT_W-1:0]      hold_cnt;
    logic [CNT_W-1:0]      hold_cnt_nxt;
    logic                  hold_active;

    logic                  stall_any;
    logic [IDX_W-1:0]      stall_top;
    logic                  flush_any;
    logic [IDX_W-1:0]      win_idx;
    logic [ADDR_W-1:0]     win_tgt;
    logic [NUM_STAGES-1:0] stall_raw;
    logic [NUM_STAGES-1:0] bubble_raw;
    logic [NUM_STAGES-1:0] flush_c;

    assign hold_active = (hold_cnt != '0);

    // Oldest stalled stage: everything at or below it holds, the stage above gets a bubble.
    always_comb begin
        stall_any = 1'b0;
        stall_top = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stall_req[i]) begin
                stall_any = 1'b1;
                stall_top = IDX_W'(i);
            end
        end
        stall_raw  = '0;
        bubble_raw = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stall_raw[i] = stall_any && (IDX_W'(i) <= stall_top);
        end
        for (int i = 1; i < NUM_STAGES; i++) begin
            bubble_raw[i] = stall_any && (IDX_W'(i - 1) == stall_top);
        end
    end

    // Oldest accepted flush wins; a stalled stage (or one below a stall) cannot flush.
    always_comb begin
        flush_any = 1'b0;
        win_idx   = '0;
        win_tgt   = '0;
        for (int s = 1; s < NUM_STAGES; s++) begin
            if (flush_req[s] && (!stall_any || (IDX_W'(s) > stall_top))) begin
                flush_any = 1'b1;
                win_idx   = IDX_W'(s);
                win_tgt   = flush_tgt[s*ADDR_W +: ADDR_W];
            end
        end
        flush_c = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            flush_c[i] = flush_any && (IDX_W'(i) < win_idx);
        end
        flush_c[0] = flush_c[0] | hold_active;
    end

    // Flush overrides stall and bubble on the same stage.
    assign flush  = flush_c;
    assign stall  = stall_raw & ~flush_c;
    assign bubble = bubble_raw & ~flush_c;

    // Hold counter: reload on accepted flush, otherwise count down to zero.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if (flush_any) begin
            hold_cnt_nxt = CNT_W'(HOLD_CYCLES - 1);
        end else if (hold_active) begin
            hold_cnt_nxt = hold_cnt - CNT_W'(1);
        end
    end

    // Counter, busy flag and redirect register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt       <= '0;
            busy           <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            hold_cnt       <= hold_cnt_nxt;
            busy           <= (hold_cnt_nxt != '0);
            redirect_valid <= flush_any;
            if (flush_any) begin
                redirect_pc <= win_tgt;
            end
        end
    end

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
module tb_pipe_flush_ctrl;

    localparam int N = 5;
    localparam int H = 2;
    localparam int A = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   flush_req;
    logic [N*A-1:0] flush_tgt;
    logic [N-1:0]   stall_req;
    logic [N-1:0]   flush;
    logic [N-1:0]   stall;
    logic [N-1:0]   bubble;
    logic           redirect_valid;
    logic [A-1:0]   redirect_pc;
    logic           busy;

    logic [A-1:0]   tgt [N];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int           m_cnt;
    logic         m_rv;
    logic [A-1:0] m_pc;
    int           m_w;
    logic [N-1:0] e_flush, e_stall, e_bubble;

    for (genvar g = 0; g < N; g++) begin : g_tgt
        assign flush_tgt[g*A +: A] = tgt[g];
    end

    always #5 clk = ~clk;

    pipe_flush_ctrl #(.NUM_STAGES(N), .HOLD_CYCLES(H), .ADDR_W(A)) dut (
        .clk(clk), .rst_n(rst_n),
        .flush_req(flush_req), .flush_tgt(flush_tgt), .stall_req(stall_req),
        .flush(flush), .stall(stall), .bubble(bubble),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    task automatic chk(input string name, input logic [A-1:0] got, input logic [A-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_rv  = 1'b0;
        m_pc  = '0;
    endtask

    // Expected outputs from the rules: stall top t, flush winner w, hold forcing IF flush.
    task automatic model_eval();
        int t;
        t   = -1;
        m_w = -1;
        for (int i = 0; i < N; i++) if (stall_req[i]) t = i;
        for (int s = 1; s < N; s++) if (flush_req[s] && s > t) m_w = s;
        e_flush = '0; e_stall = '0; e_bubble = '0;
        for (int i = 0; i < N; i++) begin
            if (i < m_w) e_flush[i] = 1'b1;
            if (i <= t) e_stall[i] = 1'b1;
        end
        if (m_cnt > 0) e_flush[0] = 1'b1;
        if (t >= 0 && t + 1 < N) e_bubble[t+1] = 1'b1;
        e_stall  = e_stall & ~e_flush;
        e_bubble = e_bubble & ~e_flush;
    endtask

    // Drive inputs (called just after a negedge), settle, compare every output.
    task automatic drive(input logic [N-1:0] fr, input logic [N-1:0] sr);
        flush_req = fr;
        stall_req = sr;
        #1;
        model_eval();
        chk("flush", A'(flush), A'(e_flush));
        chk("stall", A'(stall), A'(e_stall));
        chk("bubble", A'(bubble), A'(e_bubble));
        chk("redirect_valid", A'(redirect_valid), A'(m_rv));
        chk("redirect_pc", redirect_pc, m_pc);
        chk("busy", A'(busy), A'(m_cnt > 0));
    endtask

    // Clock edge: advance the model with the inputs that were applied.
    task automatic advance();
        @(posedge clk);
        if (rst_n) begin
            if (m_w >= 0) begin
                m_cnt = H - 1;
                m_rv  = 1'b1;
                m_pc  = tgt[m_w];
            end else begin
                m_rv = 1'b0;
                if (m_cnt > 0) m_cnt = m_cnt - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush_req = '0;
        stall_req = '0;
        for (int i = 0; i < N; i++) tgt[i] = A'(32'h1000 * (i + 1));
        model_reset();
        repeat (2) @(negedge clk);

        // 1: reset state
        drive(5'b00000, 5'b00000);
        chk("t1_flush", A'(flush), 32'h0);
        chk("t1_stall", A'(stall), 32'h0);
        chk("t1_bubble", A'(bubble), 32'h0);
        chk("t1_rv", A'(redirect_valid), 32'h0);
        chk("t1_busy", A'(busy), 32'h0);
        rst_n = 1'b1;
        advance();

        // 2: single EX flush with hold of two cycles
        tgt[2] = 32'h0000_0100;
        drive(5'b00100, 5'b00000);
        chk("t2_flush0", A'(flush), 32'h03);
        advance();
        drive(5'b00000, 5'b00000);
        chk("t2_flush1", A'(flush), 32'h01);
        chk("t2_busy1", A'(busy), 32'h1);
        chk("t2_rv1", A'(redirect_valid), 32'h1);
        chk("t2_pc1", redirect_pc, 32'h100);
        advance();
        drive(5'b00000, 5'b00000);
        chk("t2_flush2", A'(flush), 32'h0);
        chk("t2_busy2", A'(busy), 32'h0);
        chk("t2_rv2", A'(redirect_valid), 32'h0);
        advance();

        // 3: simultaneous requests, oldest wins
        tgt[3] = 32'h0000_0200;
        drive(5'b01100, 5'b00000);
        chk("t3_flush", A'(flush), 32'h07);
        advance();
        drive(5'b00000, 5'b00000);
        chk("t3_pc", redirect_pc, 32'h200);
        advance();
        drive(5'b00000, 5'b00000);
        advance();

        // 4: stall alone, then a masked flush from the stalled stage
        drive(5'b00000, 5'b00100);
        chk("t4_stall", A'(stall), 32'h07);
        chk("t4_bubble", A'(bubble), 32'h08);
        chk("t4_flush", A'(flush), 32'h0);
        drive(5'b00100, 5'b00100);
        chk("t4_masked", A'(flush), 32'h0);
        advance();
        drive(5'b00000, 5'b00000);
        chk("t4_rv", A'(redirect_valid), 32'h0);
        advance();

        // 5: older flush beats younger stall
        drive(5'b01000, 5'b00010);
        chk("t5_flush", A'(flush), 32'h07);
        chk("t5_stall", A'(stall), 32'h0);
        chk("t5_bubble", A'(bubble), 32'h0);
        advance();
        drive(5'b00000, 5'b00000);
        advance();
        drive(5'b00000, 5'b00000);
        advance();

        // 6: hold restart, then reset during hold
        drive(5'b00100, 5'b00000);
        advance();
        drive(5'b01000, 5'b00000);
        chk("t6_busy_a", A'(busy), 32'h1);
        advance();
        drive(5'b00000, 5'b00000);
        chk("t6_busy_b", A'(busy), 32'h1);
        chk("t6_pc", redirect_pc, 32'h200);
        chk("t6_rv", A'(redirect_valid), 32'h1);
        advance();
        drive(5'b00000, 5'b00000);
        chk("t6_busy_c", A'(busy), 32'h0);
        advance();
        drive(5'b00100, 5'b00000);
        advance();
        drive(5'b00000, 5'b00000);
        chk("t6_busy_pre", A'(busy), 32'h1);
        pulse_reset();
        drive(5'b00000, 5'b00000);
        chk("t6_rst_busy", A'(busy), 32'h0);
        chk("t6_rst_flush", A'(flush), 32'h0);
        chk("t6_rst_rv", A'(redirect_valid), 32'h0);
        rst_n = 1'b1;
        advance();
        drive(5'b00000, 5'b00000);
        chk("t6_post_flush", A'(flush), 32'h0);
        advance();

        // Randomized traffic with occasional mid-cycle resets
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] fr, sr;
            for (int i = 0; i < N; i++) tgt[i] = $urandom;
            fr = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            sr = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 50) == 0) begin
                pulse_reset();
                drive(fr, sr);
                rst_n = 1'b1;
            end else begin
                drive(fr, sr);
            end
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_flush_ctrl.md
Name: pipe_flush_ctrl

Overview:
Parametrised flush/stall arbiter for the in-order RV32I pipeline. It generalises the two-input ID flush OR to N stages, with these additions:
- Per-stage flush and stall requests.
- Oldest-wins arbitration.
- Multi-cycle flush hold for fetch latency.
- A registered redirect PC.
It sits beside the pipeline registers. It drives their flush/stall/bubble controls and the fetch redirect.

Parameters:
NUM_STAGES, 5, pipeline depth; stage 0 = IF (youngest), NUM_STAGES-1 = oldest (WB); legal 2..8
HOLD_CYCLES, 1, cycles IF flush is asserted per accepted flush (covers in-flight fetches); legal 1..15
ADDR_W, 32, redirect address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_req  in  NUM_STAGES  stage s requests flush of all younger stages (0..s-1); bit 0 ignored
flush_tgt  in  NUM_STAGES*ADDR_W  redirect target of stage s at slice [s*ADDR_W +: ADDR_W]
stall_req  in  NUM_STAGES  stage s cannot advance this cycle
flush  out  NUM_STAGES  clear pipeline register of stage i
stall  out  NUM_STAGES  hold pipeline register of stage i
bubble  out  NUM_STAGES  insert NOP into stage i
redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  out  ADDR_W  registered winning target
busy  out  1  flush hold in progress

Behaviour:
- Reset (rst_n=0, async): hold counter=0, redirect_valid=0, redirect_pc=0, busy=0. Combinational outputs follow the rules below with counter=0.
- Stall resolution (combinational):
  - t = highest index with stall_req set.
  - Raw: stall[i]=1 for i<=t; bubble[t+1]=1 if t+1<NUM_STAGES.
  - No stall_req set: all stall/bubble 0.
- Flush masking: flush_req[s] is accepted only if s>t (a stalled stage cannot flush) and s>=1.
- Flush arbitration: w = highest accepted index (oldest wins). flush[i]=1 for i<w.
- Flush beats stall and bubble: for any i with flush[i]=1, stall[i]=0 and bubble[i]=0.
- Hold counter, 4 bits:
  - On accepted flush: counter <= HOLD_CYCLES-1.
  - Else if counter>0: counter decrements.
  - While counter>0: flush[0]=1, stall[0]=0, busy=1.
  - A new accepted flush during hold reloads the counter (restart) and overrides the old target.
- Redirect:
  - On accepted flush at edge k: redirect_valid=1 and redirect_pc=flush_tgt[w] during cycle k+1.
  - redirect_valid drops the next cycle unless another flush is accepted.
  - redirect_pc holds its value when not updated.
- Latency: flush/stall/bubble are same-cycle combinational; redirect is 1 cycle.
- Simultaneous flush_req from several stages: only w's target is used; younger requests are discarded, not queued.
- HOLD_CYCLES=1: counter never leaves 0; behaviour reduces to a pure combinational OR-tree plus redirect register.
- Reset asserted mid-hold: counter and redirect clear immediately; no residual flush[0] after rst_n rises.

Test Plan:
All scenarios use NUM_STAGES=5, HOLD_CYCLES=2, ADDR_W=32.
1. Reset with flush_req=0, stall_req=0 -> flush=00000, stall=00000, bubble=00000, redirect_valid=0, busy=0.
2. flush_req=00100 (EX) for one cycle, flush_tgt[2]=0x0000_0100 -> same cycle flush=00011. Next cycle: flush=00001, busy=1, redirect_valid=1, redirect_pc=0x100. Cycle after: all 0.
3. flush_req=01100 with tgt[3]=0x200, tgt[2]=0x100 -> flush=00111; next cycle redirect_pc=0x200.
4. stall_req=00100 alone -> stall=00111, bubble=01000, flush=00000. Adding flush_req=00100 in the same cycle -> request masked, flush=00000.
5. stall_req=00010 with flush_req=01000 -> flush=00111, stall=00000, bubble=00000.
6. Hold restart and reset:
   - flush_req=00100, then flush_req=01000 during the hold cycle -> counter reloads, busy stays 1 for 2 more cycles, redirect_pc updates to tgt[3].
   - Pulse rst_n=0 during the hold -> busy=0 and flush=00000 at once.
